// File: rtl/fifo_word_accum_if.sv
// Byte-capture / word-output bundle between the FIFO read controller,
// the word accumulator and the downstream word consumer.
interface fifo_word_accum_if #(
    parameter int BYTES = 4
) ();
    localparam int SUM_W = 8 + $clog2(BYTES);

    logic                 rd;
    logic [7:0]           q;
    logic                 clear;
    logic                 done;
    logic                 out_ready;
    logic [8*BYTES-1:0]   word_out;
    logic [SUM_W-1:0]     sum_out;
    logic                 out_valid;
    logic [2:0]           byte_cnt;
    logic                 overrun;
    logic                 frame_err;

    // Driver side: controller plus downstream consumer.
    modport master (
        output rd, q, clear, done, out_ready,
        input  word_out, sum_out, out_valid, byte_cnt, overrun, frame_err
    );

    // Accumulator side.
    modport slave (
        input  rd, q, clear, done, out_ready,
        output word_out, sum_out, out_valid, byte_cnt, overrun, frame_err
    );
endinterface

// File: rtl/fifo_word_accum.sv
// Packs FIFO read bytes into BYTES-wide words with a running byte sum,
// hands each word out through a one-entry valid/ready holding register.
module fifo_word_accum #(
    parameter int BYTES     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk_2,
    input  logic             reset,
    fifo_word_accum_if.slave bus
);
    localparam int         SUM_W  = 8 + $clog2(BYTES);
    localparam int         WORD_W = 8 * BYTES;
    localparam logic [2:0] LAST   = 3'(BYTES - 1);

    typedef enum logic {S_EMPTY, S_FULL} out_state_e;

    out_state_e         state_q, state_d;
    logic               rd_p1_q, done_p1_q;
    logic [2:0]         cnt_q, cnt_d, cnt_base;
    logic [WORD_W-1:0]  part_q, part_d, part_base, part_ins;
    logic [SUM_W-1:0]   psum_q, psum_d, psum_base, psum_ins;
    logic [WORD_W-1:0]  word_q, word_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic               ovr_q, ovr_d;
    logic               ferr_q, ferr_d;
    logic               complete;

    function automatic logic [WORD_W-1:0] place_byte(input logic [WORD_W-1:0] w,
                                                     input logic [7:0]        b,
                                                     input logic [2:0]        idx);
        logic [WORD_W-1:0] r;
        logic [2:0]        slot;
        r    = w;
        slot = LSB_FIRST ? idx : (LAST - idx);
        for (int i = 0; i < BYTES; i++) begin
            if (slot == 3'(i)) r[i*8 +: 8] = b;
        end
        return r;
    endfunction

    // Stage p1: rd/done realigned with q; clear wins over the old partial
    // word so a byte arriving with clear lands as byte 0.
    always_comb begin
        cnt_base  = bus.clear ? '0 : cnt_q;
        part_base = bus.clear ? '0 : part_q;
        psum_base = bus.clear ? '0 : psum_q;
        part_ins  = place_byte(part_base, bus.q, cnt_base);
        psum_ins  = psum_base + {{(SUM_W-8){1'b0}}, bus.q};
        complete  = rd_p1_q && (cnt_base == LAST);

        cnt_d  = cnt_base;
        part_d = part_base;
        psum_d = psum_base;
        if (rd_p1_q) begin
            if (complete) begin
                cnt_d  = '0;
                part_d = '0;
                psum_d = '0;
            end else begin
                cnt_d  = cnt_base + 3'd1;
                part_d = part_ins;
                psum_d = psum_ins;
            end
        end

        // A misaligned done only flags; it never forces a short word out.
        ferr_d = ferr_q | (done_p1_q & (~rd_p1_q | (cnt_base != LAST)));
    end

    // Stage p2: holding register; a completion while FULL and stalled is dropped.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        sum_d   = sum_q;
        ovr_d   = ovr_q;
        case (state_q)
            S_EMPTY: begin
                if (complete) begin
                    state_d = S_FULL;
                    word_d  = part_ins;
                    sum_d   = psum_ins;
                end
            end
            S_FULL: begin
                if (complete) begin
                    if (bus.out_ready) begin
                        word_d = part_ins;
                        sum_d  = psum_ins;
                    end else begin
                        ovr_d = 1'b1;
                    end
                end else if (bus.out_ready) begin
                    state_d = S_EMPTY;
                end
            end
        endcase
    end

    always_ff @(posedge clk_2 or posedge reset) begin
        if (reset) begin
            state_q   <= S_EMPTY;
            rd_p1_q   <= 1'b0;
            done_p1_q <= 1'b0;
            cnt_q     <= '0;
            part_q    <= '0;
            psum_q    <= '0;
            word_q    <= '0;
            sum_q     <= '0;
            ovr_q     <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_p1_q   <= bus.rd;
            done_p1_q <= bus.done;
            cnt_q     <= cnt_d;
            part_q    <= part_d;
            psum_q    <= psum_d;
            word_q    <= word_d;
            sum_q     <= sum_d;
            ovr_q     <= ovr_d;
            ferr_q    <= ferr_d;
        end
    end

    assign bus.word_out  = word_q;
    assign bus.sum_out   = sum_q;
    assign bus.out_valid = (state_q == S_FULL);
    assign bus.byte_cnt  = cnt_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_fifo_word_accum.sv
// Bench for fifo_word_accum: an LSB-first and an MSB-first instance share
// one stimulus stream and are checked against a queue-based reference model.
module tb_fifo_word_accum;
    localparam int BYTES = 4;
    localparam int SUM_W = 8 + $clog2(BYTES);
    localparam int WW    = 8 * BYTES;

    logic clk_2 = 1'b0;
    logic reset;
    always #5 clk_2 = ~clk_2;

    fifo_word_accum_if #(.BYTES(BYTES)) bl ();
    fifo_word_accum_if #(.BYTES(BYTES)) bm ();

    fifo_word_accum #(.BYTES(BYTES), .LSB_FIRST(1'b1)) u_lsb (
        .clk_2(clk_2), .reset(reset), .bus(bl.slave));
    fifo_word_accum #(.BYTES(BYTES), .LSB_FIRST(1'b0)) u_msb (
        .clk_2(clk_2), .reset(reset), .bus(bm.slave));

    int chk_cnt  = 0;
    int pass_cnt = 0;

    // Reference model state: collected bytes of the partial word plus output holder.
    logic [7:0]       part[$];
    bit               m_rdd, m_dd, m_valid, m_ovr, m_fe;
    logic [WW-1:0]    m_word_l, m_word_m;
    logic [SUM_W-1:0] m_sum;
    logic [7:0]       q_nxt;

    typedef struct {
        bit rd; bit done; bit clr; bit rdy; logic [7:0] nb;
        bit ev; logic [2:0] ecnt; logic [31:0] ewl; logic [31:0] ewm; logic [SUM_W-1:0] esum;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic model_reset();
        part.delete();
        m_rdd = 0; m_dd = 0; m_valid = 0; m_ovr = 0; m_fe = 0;
        m_word_l = '0; m_word_m = '0; m_sum = '0;
    endtask

    task automatic model_step(input bit rd, input bit done, input bit clr, input bit rdy,
                              input logic [7:0] qv);
        bit            cmpl;
        logic [WW-1:0] wl, wm;
        int            s;
        cmpl = 0; wl = '0; wm = '0; s = 0;
        if (clr) part.delete();
        if (m_dd && (!m_rdd || part.size() != BYTES - 1)) m_fe = 1;
        if (m_rdd) begin
            part.push_back(qv);
            if (part.size() == BYTES) begin
                cmpl = 1;
                foreach (part[i]) begin
                    wl = wl | (WW'(part[i]) << (8 * i));
                    wm = wm | (WW'(part[i]) << (8 * (BYTES - 1 - i)));
                    s  = s + int'(part[i]);
                end
                part.delete();
            end
        end
        if (cmpl) begin
            if (!m_valid || rdy) begin
                m_valid = 1; m_word_l = wl; m_word_m = wm; m_sum = SUM_W'(s);
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 0;
        end
        m_rdd = rd; m_dd = done;
    endtask

    task automatic drive(input bit rd, input bit done, input bit clr, input bit rdy,
                         input logic [7:0] qv);
        bl.rd = rd; bl.done = done; bl.clear = clr; bl.out_ready = rdy; bl.q = qv;
        bm.rd = rd; bm.done = done; bm.clear = clr; bm.out_ready = rdy; bm.q = qv;
    endtask

    task automatic compare_model();
        chk("valid", 64'(bl.out_valid), 64'(m_valid));
        chk("valid_msb", 64'(bm.out_valid), 64'(m_valid));
        chk("byte_cnt", 64'(bl.byte_cnt), 64'(part.size()));
        chk("overrun", 64'(bl.overrun), 64'(m_ovr));
        chk("frame_err", 64'(bl.frame_err), 64'(m_fe));
        if (m_valid) begin
            chk("word_lsb", 64'(bl.word_out), 64'(m_word_l));
            chk("word_msb", 64'(bm.word_out), 64'(m_word_m));
            chk("sum", 64'(bl.sum_out), 64'(m_sum));
        end
    endtask

    // One clk_2 cycle; nb is the byte the FIFO presents on q one cycle later.
    task automatic cyc(input bit rd, input bit done, input bit clr, input bit rdy,
                       input logic [7:0] nb);
        logic [7:0] qcur;
        qcur  = q_nxt;
        q_nxt = nb;
        drive(rd, done, clr, rdy, qcur);
        @(posedge clk_2);
        model_step(rd, done, clr, rdy, qcur);
        @(negedge clk_2);
        compare_model();
    endtask

    task automatic send4(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input bit rdy);
        cyc(1, 0, 0, rdy, b0);
        cyc(1, 0, 0, rdy, b1);
        cyc(1, 0, 0, rdy, b2);
        cyc(1, 1, 0, rdy, b3);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        q_nxt = 8'h00;
        @(posedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int rcnt;
        bit rd, dn, cl, rdy;
        tbl[0] = '{1, 0, 0, 1, 8'h11, 0, 3'd0, 32'h0, 32'h0, '0};
        tbl[1] = '{1, 0, 0, 1, 8'h22, 0, 3'd1, 32'h0, 32'h0, '0};
        tbl[2] = '{1, 0, 0, 1, 8'h33, 0, 3'd2, 32'h0, 32'h0, '0};
        tbl[3] = '{1, 1, 0, 1, 8'h44, 0, 3'd3, 32'h0, 32'h0, '0};
        tbl[4] = '{0, 0, 0, 1, 8'h00, 1, 3'd0, 32'h44332211, 32'h11223344, 10'h0AA};
        tbl[5] = '{0, 0, 0, 1, 8'h00, 0, 3'd0, 32'h0, 32'h0, '0};
        tbl[6] = '{0, 0, 0, 1, 8'h00, 0, 3'd0, 32'h0, 32'h0, '0};

        reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        q_nxt = 8'h00;
        model_reset();
        repeat (2) @(negedge clk_2);
        chk("rst_valid", 64'(bl.out_valid), 64'd0);
        chk("rst_word", 64'(bl.word_out), 64'd0);
        chk("rst_sum", 64'(bl.sum_out), 64'd0);
        chk("rst_cnt", 64'(bl.byte_cnt), 64'd0);
        chk("rst_flags", 64'({bl.overrun, bl.frame_err}), 64'd0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            cyc(tbl[i].rd, tbl[i].done, tbl[i].clr, tbl[i].rdy, tbl[i].nb);
            chk("tbl_valid", 64'(bl.out_valid), 64'(tbl[i].ev));
            chk("tbl_cnt", 64'(bl.byte_cnt), 64'(tbl[i].ecnt));
            if (tbl[i].ev) begin
                chk("tbl_word_lsb", 64'(bl.word_out), 64'(tbl[i].ewl));
                chk("tbl_word_msb", 64'(bm.word_out), 64'(tbl[i].ewm));
                chk("tbl_sum", 64'(bl.sum_out), 64'(tbl[i].esum));
            end
        end
        chk("tbl_frame_err", 64'(bl.frame_err), 64'd0);

        // Full-scale bytes: sum needs the extra bits.
        do_reset();
        send4(8'hFF, 8'hFF, 8'hFF, 8'hFF, 1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("ff_sum", 64'(bl.sum_out), 64'h3FC);
        chk("ff_valid", 64'(bl.out_valid), 64'd1);

        // Stalled consumer: second word dropped, held word kept.
        do_reset();
        send4(8'h11, 8'h22, 8'h33, 8'h44, 0);
        send4(8'h01, 8'h02, 8'h03, 8'h04, 0);
        cyc(0, 0, 0, 0, 8'h00);
        chk("ovr_word", 64'(bl.word_out), 64'h44332211);
        chk("ovr_flag", 64'(bl.overrun), 64'd1);
        chk("ovr_valid", 64'(bl.out_valid), 64'd1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("ovr_drain", 64'(bl.out_valid), 64'd0);

        // Back-to-back: pop and load on the same edge.
        do_reset();
        send4(8'h11, 8'h22, 8'h33, 8'h44, 0);
        send4(8'h01, 8'h02, 8'h03, 8'h04, 0);
        cyc(0, 0, 0, 1, 8'h00);
        chk("b2b_valid", 64'(bl.out_valid), 64'd1);
        chk("b2b_word", 64'(bl.word_out), 64'h04030201);
        chk("b2b_ovr", 64'(bl.overrun), 64'd0);
        cyc(0, 0, 0, 1, 8'h00);
        chk("b2b_drain", 64'(bl.out_valid), 64'd0);

        // clear drops a partial word; clear with a capture keeps that byte.
        do_reset();
        cyc(1, 0, 0, 1, 8'h55);
        cyc(1, 0, 0, 1, 8'h66);
        cyc(0, 0, 0, 1, 8'h00);
        chk("clr_pre", 64'(bl.byte_cnt), 64'd2);
        cyc(0, 0, 1, 1, 8'h00);
        chk("clr_cnt", 64'(bl.byte_cnt), 64'd0);
        send4(8'hA0, 8'hA1, 8'hA2, 8'hA3, 1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("clr_word", 64'(bl.word_out), 64'hA3A2A1A0);
        chk("clr_sum", 64'(bl.sum_out), 64'h286);
        cyc(1, 0, 0, 1, 8'h77);
        cyc(0, 0, 1, 1, 8'h00);
        chk("clr_rdd_cnt", 64'(bl.byte_cnt), 64'd1);

        // Misaligned done, then asynchronous reset mid-word.
        do_reset();
        cyc(1, 0, 0, 1, 8'h01);
        cyc(1, 1, 0, 1, 8'h02);
        cyc(0, 0, 0, 1, 8'h00);
        cyc(0, 0, 0, 1, 8'h00);
        chk("ferr_set", 64'(bl.frame_err), 64'd1);
        cyc(0, 0, 0, 1, 8'h00);
        chk("ferr_sticky", 64'(bl.frame_err), 64'd1);
        chk("ferr_cnt", 64'(bl.byte_cnt), 64'd2);
        #2 reset = 1'b1;
        #1;
        chk("arst_cnt", 64'(bl.byte_cnt), 64'd0);
        chk("arst_flags", 64'({bl.overrun, bl.frame_err, bl.out_valid}), 64'd0);
        chk("arst_data", 64'({bl.word_out, bl.sum_out}), 64'd0);
        drive(0, 0, 0, 0, 8'h00);
        q_nxt = 8'h00;
        @(posedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
        model_reset();

        // Randomized traffic against the model, with periodic resets.
        rcnt = 0;
        for (int n = 0; n < 2400; n++) begin
            if (n % 300 == 299) begin
                do_reset();
                rcnt = 0;
            end
            rd  = ($urandom % 4) != 0;
            cl  = ($urandom % 40) == 0;
            rdy = ($urandom % 2) == 0;
            dn  = rd && (((rcnt % BYTES) == BYTES - 1) ^ (($urandom % 60) == 0));
            if (rd) rcnt++;
            cyc(rd, dn, cl, rdy, 8'($urandom));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule

// File: doc/fifo_word_accum.md
Name: fifo_word_accum

Overview:
- Datapath stage directly downstream of the 2 MHz FIFO read controller, in the 2 MHz domain.
- Captures bytes popped from the FIFO, packs each group of BYTES bytes into one word, and computes the byte sum of that word.
- Presents each completed word to the next consumer through a valid/ready holding register.
- Checks the controller's clear/done framing against its own byte count.

Parameters:
- BYTES, 4, bytes per word; legal range 2..8.
- LSB_FIRST, 1, 1 = first byte read lands in bits [7:0]; 0 = first byte lands in the top byte.

Ports:
- clk_2  in  1  2 MHz clock.
- reset  in  1  asynchronous, active-high reset.
- rd  in  1  FIFO read strobe from the controller; FIFO data is valid on q the cycle after rd.
- q  in  8  FIFO read data.
- clear  in  1  controller clear; discard any partial word.
- done  in  1  controller flag; asserted with the rd of the last byte of a word.
- word_out  out  8*BYTES  packed word, held stable while out_valid=1.
- sum_out  out  8+clog2(BYTES)  unsigned sum of the word's bytes; never wraps.
- out_valid  out  1  word_out and sum_out are valid.
- out_ready  in  1  consumer accepts the word when out_valid and out_ready are both 1.
- byte_cnt  out  3  number of bytes in the current partial word (0..BYTES-1).
- overrun  out  1  sticky; a completed word was dropped.
- frame_err  out  1  sticky; done arrived misaligned with byte_cnt.

Behaviour:
- Reset (asynchronous, active-high):
  - All outputs 0, including word_out, sum_out, out_valid, byte_cnt, overrun and frame_err.
  - Internal rd_d, done_d, partial word and partial sum are 0.
- Pipeline alignment:
  - rd_d and done_d are rd and done delayed one clk_2.
  - A byte is captured from q on every cycle with rd_d=1.
- Capture:
  - The captured byte goes into slot byte_cnt; slot placement follows LSB_FIRST.
  - The partial sum adds the zero-extended byte.
  - byte_cnt increments by 1.
- Word completion: on a capture with byte_cnt = BYTES-1:
  - byte_cnt wraps to 0.
  - The completed word and sum go to the output register the same edge, provided the output register is free. They are visible the cycle after the edge.
  - The partial word and sum reset to 0.
- Output register states: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY -> FULL on word completion.
  - FULL -> EMPTY when out_ready=1 and no completion occurs that edge.
  - FULL with out_ready=1 and a completion on the same edge: the new word loads and out_valid stays 1 (back-to-back, no bubble).
  - FULL with out_ready=0 and a completion: the new word is dropped, overrun is set to 1, and the held word is unchanged.
  - Minimum latency from the rd of the last byte to out_valid: 2 cycles.
- clear:
  - On a cycle with clear=1, byte_cnt, the partial word and the partial sum go to 0.
  - The output register and the sticky flags are untouched.
  - clear together with rd_d: clear first, then the byte is captured as byte 0, so byte_cnt becomes 1.
- Framing check:
  - If done_d=1 on a capture cycle where byte_cnt != BYTES-1, or done_d=1 without rd_d, frame_err is set to 1.
  - The word is not force-completed.
- Sticky flags: overrun and frame_err clear only on reset.
- Reset mid-word or while FULL: everything returns to reset values immediately, and the pending word is lost.
- rd with no following valid q is not checked; empty handling belongs to the controller.

Test Plan:
- BYTES=4, LSB_FIRST=1: rd on 4 consecutive cycles, q=0x11,0x22,0x33,0x44, done with the 4th rd, out_ready=1 -> word_out=0x44332211, sum_out=0x0AA, out_valid=1 for exactly 1 cycle, 2 cycles after the 4th rd; frame_err=0.
- Bytes 0xFF x4 -> sum_out=0x3FC (10 bits, no wrap); with LSB_FIRST=0 and bytes 0x11..0x44 -> word_out=0x11223344.
- out_ready=0 for the 1st word, then a 2nd word 0x01,0x02,0x03,0x04 completes -> word_out stays 0x44332211, overrun=1; out_ready=1 -> out_valid drops next cycle.
- FULL with out_ready=1 on the same edge as the 2nd completion -> out_valid stays 1, word_out=0x04030201, overrun=0.
- 2 bytes captured, then clear -> byte_cnt=0; 4 new bytes 0xA0..0xA3 -> word_out=0xA3A2A1A0, sum_out=0x286. Also clear on the same cycle as rd_d -> byte_cnt=1.
- done with the 2nd rd -> frame_err=1 and stays 1; assert reset mid-word -> all outputs 0 asynchronously, before the next clk_2 edge.
